// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-through/no-allocate data cache sequencer
// with a sequential flush and saturating hit/miss counters.
module dcache_controller #(
   parameter int DATA_WIDTH        = 32,
   parameter int SET_ADDRESS_WIDTH = 3,
   parameter int TAG_WIDTH         = 27,
   parameter int BYTE_WIDTH        = 8,
   parameter int CNT_WIDTH         = 16
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic                               cpu_req,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   cpu_be,
   input  logic [DATA_WIDTH-1:0]              cpu_addr,
   input  logic [DATA_WIDTH-1:0]              cpu_wdata,
   output logic [DATA_WIDTH-1:0]              cpu_rdata,
   output logic                               stall,
   input  logic                               flush,
   output logic                               flush_busy,
   output logic                               mem_req,
   output logic                               mem_we,
   output logic [DATA_WIDTH/BYTE_WIDTH-1:0]   mem_be,
   output logic [DATA_WIDTH-1:0]              mem_addr,
   output logic [DATA_WIDTH-1:0]              mem_wdata,
   input  logic [DATA_WIDTH-1:0]              mem_rdata,
   input  logic                               mem_ready,
   output logic [CNT_WIDTH-1:0]               hit_count,
   output logic [CNT_WIDTH-1:0]               miss_count
);
   localparam int NB = DATA_WIDTH / BYTE_WIDTH;
   localparam int NS = 2 ** SET_ADDRESS_WIDTH;

   typedef enum logic [2:0] {IDLE, RD_MISS, WR_THRU, RESPOND, FLUSH} state_t;
   state_t state, state_nxt;

   logic [NS-1:0]                valid;
   logic [TAG_WIDTH-1:0]         tag_array [NS];
   logic [DATA_WIDTH-1:0]        data_array [NS];
   logic [DATA_WIDTH-1:0]        rdata_q;
   logic [SET_ADDRESS_WIDTH-1:0] set_idx, lset, flush_idx;
   logic [TAG_WIDTH-1:0]         tag, ltag;
   logic                         hit, hit_q, load, accept, done;

   assign set_idx    = cpu_addr[SET_ADDRESS_WIDTH+1:2];
   assign tag        = cpu_addr[DATA_WIDTH-1:SET_ADDRESS_WIDTH+2];
   // mem_addr doubles as the latched request address once IDLE is left
   assign lset       = mem_addr[SET_ADDRESS_WIDTH+1:2];
   assign ltag       = mem_addr[DATA_WIDTH-1:SET_ADDRESS_WIDTH+2];
   assign load       = ~|cpu_be;
   assign hit        = valid[set_idx] && tag_array[set_idx] == tag;
   assign accept     = state == IDLE && cpu_req && !flush;
   assign done       = (state == RD_MISS || state == WR_THRU) && mem_ready;
   assign stall      = cpu_req && !(state == IDLE && !flush && load && hit) && state != RESPOND;
   assign cpu_rdata  = (state == IDLE && load && hit) ? data_array[set_idx] : rdata_q;
   assign flush_busy = state == FLUSH;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:             state_nxt = flush ? FLUSH : (cpu_req && !(load && hit)) ? (load ? RD_MISS : WR_THRU) : IDLE;
         RD_MISS, WR_THRU: state_nxt = mem_ready ? RESPOND : state;
         RESPOND:          state_nxt = IDLE;
         FLUSH:            state_nxt = (flush_idx == '1) ? IDLE : FLUSH;
         default:          state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         valid      <= '0;
         flush_idx  <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_be     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         rdata_q    <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         state <= state_nxt;
         if (accept && !(load && hit)) begin
            mem_req   <= 1'b1;
            mem_we    <= !load;
            mem_be    <= cpu_be;
            mem_addr  <= cpu_addr & ~DATA_WIDTH'(3);
            mem_wdata <= cpu_wdata;
            hit_q     <= hit;
         end
         if (done) mem_req <= 1'b0;
         if (state == RD_MISS && mem_ready) begin
            valid[lset] <= 1'b1;
            rdata_q     <= mem_rdata;
         end
         if (accept && hit && !(&hit_count)) hit_count <= hit_count + CNT_WIDTH'(1);
         if (accept && !hit && !(&miss_count)) miss_count <= miss_count + CNT_WIDTH'(1);
         // flush_idx wraps back to 0 after the last set, ready for the next flush
         if (state == FLUSH) begin
            valid[flush_idx] <= 1'b0;
            flush_idx        <= flush_idx + SET_ADDRESS_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (state == RD_MISS && mem_ready) begin
         tag_array[lset]  <= ltag;
         data_array[lset] <= mem_rdata;
      end
      for (int i = 0; i < NB; i++)
         if (state == WR_THRU && mem_ready && hit_q && mem_be[i])
            data_array[lset][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
   end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Sequences the direct-mapped data cache between the load/store stage and data memory.
- Owns the valid/tag/data arrays: 8 sets, 1 word per line, byte enables WE0..WE3.
- Policy: write-through, no write-allocate. Read misses refill from memory over a req/ready handshake, and the CPU stalls until the access completes.
- Provides a sequential flush and hit/miss performance counters.

Parameters:
DATA_WIDTH, 32, address/data width
SET_ADDRESS_WIDTH, 3, set index bits (2**3 = 8 sets), index = A[4:2]
TAG_WIDTH, 27, tag bits, tag = A[31:5]
BYTE_WIDTH, 8, bits per byte lane
CNT_WIDTH, 16, width of hit/miss counters

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  synchronous, active-high reset
cpu_req  in  1  access request from memory stage
cpu_be  in  4  byte write enables {WE3,WE2,WE1,WE0}; 0000 = load
cpu_addr  in  32  byte address (A[1:0] ignored)
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data
stall  out  1  hold pipeline (combinational)
flush  in  1  invalidate all lines
flush_busy  out  1  flush in progress
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  1 = write
mem_be  out  4  byte enables to memory
mem_addr  out  32  word-aligned address ({A[31:2],2'b00})
mem_wdata  out  32  write data
mem_rdata  in  32  read data, valid when mem_ready
mem_ready  in  1  memory completes the request this cycle
hit_count  out  CNT_WIDTH  saturating lookup-hit counter
miss_count  out  CNT_WIDTH  saturating miss counter

Behaviour:
- Reset (sync, RST=1 at edge): state=IDLE; all valid bits=0; mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0; cpu_rdata=0; counters=0; flush_busy=0. Tag/data contents are don't-care. Reset mid-refill, mid-write or mid-flush aborts the operation; the next cycle is clean IDLE.
- hit = valid[set] && tag_array[set]==tag (combinational, in IDLE).
- States: IDLE, RD_MISS, WR_THRU, RESPOND, FLUSH.
- IDLE, load hit: cpu_rdata=data[set] combinationally; stall=0; hit_count++. Zero-cycle latency.
- IDLE, load miss: stall=1; miss_count++; latch addr; -> RD_MISS.
- IDLE, store (cpu_be!=0): stall=1; latch addr/wdata/be; hit_count++ on hit, else miss_count++; -> WR_THRU.
- RD_MISS: mem_req=1, mem_we=0, mem_be=0000 until mem_ready. On the mem_ready cycle: valid[set]<=1, tag<=latched tag, data<=mem_rdata, cpu_rdata<=mem_rdata; -> RESPOND.
- WR_THRU: mem_req=1, mem_we=1, mem_be/mem_wdata/mem_addr = latched values, until mem_ready. On the mem_ready cycle, if the line hit at lookup, the cache merges only the enabled byte lanes; valid/tag are unchanged. A miss leaves the cache untouched. -> RESPOND.
- RESPOND: stall=0 for exactly one cycle; cpu_rdata holds the registered value; -> IDLE. No new request is accepted in RESPOND, because the pipeline advances this cycle.
- mem_* outputs are registered and stable while mem_req=1. mem_req drops in the cycle after mem_ready. mem_ready while mem_req=0 is ignored.
- Miss latency = memory latency + 2 cycles.
- flush: sampled only in IDLE. Flush takes priority over a simultaneous cpu_req, which stalls. -> FLUSH; an index counter runs 0..7 and clears one valid bit per cycle; flush_busy=1. After index 7 -> IDLE, for a total of 8 cycles. flush asserted outside IDLE is ignored and must be re-requested.
- stall = cpu_req && !(state==IDLE && !flush && load && hit) && state!=RESPOND.
- Counters saturate at all-ones and never wrap.
- Index and tag are taken from the latched address, never from a live cpu_addr, after IDLE.

Test Plan:
- Load 0x0000_0044 cold, mem_rdata=0xDEADBEEF after 3-cycle ready -> stall 5 cycles, cpu_rdata=0xDEADBEEF, miss_count=1. Repeat load -> stall=0, same data, hit_count=1.
- Conflict: load 0x44 then 0x64 (same set 1, different tag) -> both miss; set 1 tag updated; reload of 0x44 misses again.
- Store 0x44 be=0011 wdata=0x12345678 on a cached line 0xDEADBEEF -> mem_we=1, mem_be=0011; cache word becomes 0xDEAD5678. Store to an uncached address -> memory write only, a later load misses.
- flush with all 8 sets valid and simultaneous cpu_req -> flush_busy for 8 cycles, cpu stalled, then every load misses.
- RST asserted mid-RD_MISS (mem_ready never given) -> mem_req=0 next cycle, state IDLE, all loads miss, counters=0.
- Counter saturation with CNT_WIDTH=4: 20 hits -> hit_count=15.
